// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, Gray-count conversion, then row capture and byte streaming.
// Latency: one frame per START, C_ERASE + C_EXPOSE + 256 + 1 + H*(2+W) + 1 cycles when OUT_READY stays high.
// Backpressure: OUT_READY low freezes the current beat (all OUT_* held); earlier phases do not stall.
module pixel_readout_ctrl #(
  parameter int W = 4,
  parameter int H = 4,
  parameter int C_ERASE = 4,
  parameter int C_EXPOSE = 255,
  localparam int RW = (H > 1) ? $clog2(H) : 1,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          START,
  output logic          PIX_RESET,
  output logic          ERASE,
  output logic          EXPOSE,
  output logic          CONVERT,
  output logic [H-1:0]  READBUS,
  inout  wire  [W*8-1:0] DATABUS,
  output logic [7:0]    OUT_DATA,
  output logic [RW-1:0] OUT_ROW,
  output logic [CW-1:0] OUT_COL,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST,
  output logic          FRAME_DONE,
  output logic          BUSY
);

  localparam int TMAX = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    IDLE, ERAS, EXPO, CONV, TURN, RSEL, CAPT, STRM, DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [7:0]      cnt;
  logic [7:0]      gray_q;
  logic            oe;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [7:0]      rowbuf [W];

  logic [7:0]      cnt_nxt;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_nxt;
  logic            row_is_last;

  assign cnt_nxt     = cnt + 8'd1;
  assign row_nxt     = row + RW'(1);
  assign col_nxt     = col + CW'(1);
  assign row_is_last = (row == RW'(H - 1));

  // Every column lane carries the same Gray count; bus floats whenever OE is clear.
  assign DATABUS = oe ? {W{gray_q}} : {(W*8){1'bz}};

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Sequencer: state, phase timers and all registered pixel/stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tmr        <= '0;
      cnt        <= '0;
      gray_q     <= '0;
      oe         <= 1'b0;
      row        <= '0;
      col        <= '0;
      PIX_RESET  <= 1'b0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      CONVERT    <= 1'b0;
      READBUS    <= '0;
      OUT_DATA   <= '0;
      OUT_ROW    <= '0;
      OUT_COL    <= '0;
      OUT_VALID  <= 1'b0;
      OUT_LAST   <= 1'b0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state     <= ERAS;
            ERASE     <= 1'b1;
            PIX_RESET <= 1'b1;
            BUSY      <= 1'b1;
            tmr       <= TW'(C_ERASE - 1);
          end
        end
        ERAS: begin
          if (tmr == '0) begin
            state     <= EXPO;
            ERASE     <= 1'b0;
            PIX_RESET <= 1'b0;
            EXPOSE    <= 1'b1;
            tmr       <= TW'(C_EXPOSE - 1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        EXPO: begin
          if (tmr == '0) begin
            state   <= CONV;
            EXPOSE  <= 1'b0;
            CONVERT <= 1'b1;
            oe      <= 1'b1;
            cnt     <= '0;
            gray_q  <= '0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        CONV: begin
          if (cnt == 8'hFF) begin
            state   <= TURN;
            CONVERT <= 1'b0;
            oe      <= 1'b0;
          end else begin
            cnt    <= cnt_nxt;
            gray_q <= cnt_nxt ^ (cnt_nxt >> 1);
          end
        end
        TURN: begin
          // Bus has been released for a full cycle before any row drives it.
          state   <= RSEL;
          row     <= '0;
          READBUS <= H'(1);
        end
        RSEL: begin
          state <= CAPT;
        end
        CAPT: begin
          state     <= STRM;
          READBUS   <= '0;
          col       <= '0;
          OUT_VALID <= 1'b1;
          OUT_DATA  <= g2b(DATABUS[7:0]);
          OUT_ROW   <= row;
          OUT_COL   <= '0;
          OUT_LAST  <= row_is_last && (W == 1);
        end
        STRM: begin
          if (OUT_READY) begin
            if (col == CW'(W - 1)) begin
              OUT_VALID <= 1'b0;
              OUT_LAST  <= 1'b0;
              if (row_is_last) begin
                state      <= DONE;
                FRAME_DONE <= 1'b1;
              end else begin
                state   <= RSEL;
                row     <= row_nxt;
                READBUS <= H'(1) << row_nxt;
              end
            end else begin
              col      <= col_nxt;
              OUT_COL  <= col_nxt;
              OUT_DATA <= g2b(rowbuf[col_nxt]);
              OUT_LAST <= row_is_last && (col_nxt == CW'(W - 1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Row buffer grabs every lane on the edge that ends the capture cycle.
  always_ff @(posedge clk) begin
    if (state == CAPT) begin
      for (int j = 0; j < W; j++) begin
        rowbuf[j] <= DATABUS[j*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: queue-based frame model, pixel array model, random backpressure.
// Latency: expected outputs are compared every negedge against the head of the per-cycle expectation queue.
// Backpressure: OUT_READY is randomised at 30% in later frames; stalled beats keep the queue head in place.
module tb_pixel_readout_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CE = 2;
  localparam int CX = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         START = 1'b0;
  logic         OUT_READY = 1'b1;
  logic         PIX_RESET, ERASE, EXPOSE, CONVERT;
  logic [H-1:0] READBUS;
  wire  [W*8-1:0] DATABUS;
  logic [7:0]   OUT_DATA;
  logic [1:0]   OUT_ROW, OUT_COL;
  logic         OUT_VALID, OUT_LAST, FRAME_DONE, BUSY;

  logic           tb_en;
  logic [W*8-1:0] tb_val;
  assign DATABUS = tb_en ? tb_val : {(W*8){1'bz}};

  int         checks = 0;
  int         failures = 0;
  logic       chk_en = 1'b0;
  logic       rand_ready = 1'b0;
  logic [7:0] seed = 8'd0;

  pixel_readout_ctrl #(.W(W), .H(H), .C_ERASE(CE), .C_EXPOSE(CX)) dut (
    .clk(clk), .reset(reset), .START(START),
    .PIX_RESET(PIX_RESET), .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT),
    .READBUS(READBUS), .DATABUS(DATABUS),
    .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // One record per expected output cycle of a frame.
  typedef struct packed {
    logic         erase, expose, convert, busy, drive, valid, last, done;
    logic [H-1:0] rsel;
    logic [7:0]   gray, data;
    logic [1:0]   row, col;
  } rec_t;

  rec_t q[$];
  rec_t cur = '0;

  function automatic logic [7:0] gray8(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W*8-1:0] pixrow(input logic [7:0] s, input int r);
    logic [W*8-1:0] v;
    v = '0;
    for (int c = 0; c < W; c++) v[c*8 +: 8] = gray8(8'(s + 10*r + c));
    return v;
  endfunction

  function automatic int oh2idx(input logic [H-1:0] oh);
    int k;
    k = 0;
    for (int i = 0; i < H; i++) if (oh[i]) k = i;
    return k;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] s);
    rec_t r;
    for (int i = 0; i < CE; i++) begin r = '0; r.busy = 1; r.erase = 1; q.push_back(r); end
    for (int i = 0; i < CX; i++) begin r = '0; r.busy = 1; r.expose = 1; q.push_back(r); end
    for (int i = 0; i < 256; i++) begin
      r = '0; r.busy = 1; r.convert = 1; r.drive = 1; r.gray = gray8(8'(i)); q.push_back(r);
    end
    r = '0; r.busy = 1; q.push_back(r);
    for (int rr = 0; rr < H; rr++) begin
      r = '0; r.busy = 1; r.rsel = H'(1) << rr;
      q.push_back(r);
      q.push_back(r);
      for (int c = 0; c < W; c++) begin
        r = '0; r.busy = 1; r.valid = 1;
        r.data = 8'(s + 10*rr + c);
        r.row = 2'(rr); r.col = 2'(c);
        r.last = (rr == H-1) && (c == W-1);
        q.push_back(r);
      end
    end
    r = '0; r.busy = 1; r.done = 1; q.push_back(r);
  endtask

  // Model advance: a stalled beat stays at the head; START only counts when the model is idle.
  always @(posedge clk) begin
    if (reset) q.delete();
    else if (q.size() > 0) begin
      if (!(q[0].valid && !OUT_READY)) void'(q.pop_front());
    end else if (START) push_frame(seed);
    cur = (q.size() > 0) ? q[0] : '0;
  end

  // Pixel array drives its stored Gray values on a selected row; otherwise the bench parks the bus at 0.
  always_comb begin
    tb_en  = 1'b0;
    tb_val = '0;
    if (READBUS != '0) begin
      tb_en = 1'b1;
      for (int r = 0; r < H; r++) if (READBUS[r]) tb_val = pixrow(seed, r);
    end else if (!cur.drive) begin
      tb_en = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", 64'({PIX_RESET, ERASE, EXPOSE, CONVERT, BUSY, FRAME_DONE, OUT_VALID}),
          64'({cur.erase, cur.erase, cur.expose, cur.convert, cur.busy, cur.done, cur.valid}));
      chk("readbus", 64'(READBUS), 64'(cur.rsel));
      if (cur.drive) chk("databus_gray", 64'(DATABUS), 64'({W{cur.gray}}));
      else if (cur.rsel != '0) chk("databus_pix", 64'(DATABUS), 64'(pixrow(seed, oh2idx(cur.rsel))));
      else chk("databus_released", 64'(DATABUS), 64'(0));
      if (cur.valid)
        chk("beat", 64'({OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST}),
            64'({cur.data, cur.row, cur.col, cur.last}));
    end
  end

  int         st_erase, st_expose, st_conv, st_busy, st_beats, st_lasts, st_done;
  logic [7:0] st_first [4];
  logic [7:0] st_lastg, st_first_beat, st_last_beat;
  logic [15:0] st_rbseq;
  logic [H-1:0] prev_rb;

  task automatic clr_stats();
    st_erase = 0; st_expose = 0; st_conv = 0; st_busy = 0;
    st_beats = 0; st_lasts = 0; st_done = 0;
    for (int i = 0; i < 4; i++) st_first[i] = 8'hEE;
    st_lastg = 8'hEE; st_first_beat = 8'hEE; st_last_beat = 8'hEE;
    st_rbseq = '0; prev_rb = '0;
  endtask

  // Observed-behaviour counters used for the hand-computed frame checks.
  always @(negedge clk) begin
    if (ERASE) st_erase++;
    if (EXPOSE) st_expose++;
    if (CONVERT) begin
      if (st_conv < 4) st_first[st_conv] = DATABUS[7:0];
      st_lastg = DATABUS[7:0];
      st_conv++;
    end
    if (BUSY) st_busy++;
    if (READBUS != '0 && READBUS != prev_rb) st_rbseq = {st_rbseq[11:0], READBUS};
    prev_rb = READBUS;
    if (OUT_VALID && OUT_READY) begin
      if (st_beats == 0) st_first_beat = OUT_DATA;
      st_last_beat = OUT_DATA;
      st_beats++;
      if (OUT_LAST) st_lasts++;
    end
    if (FRAME_DONE) st_done++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      OUT_READY = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke_start);
    int n;
    n = 0;
    while (!FRAME_DONE && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (poke_start) START = ($urandom_range(0, 7) == 0);
    end
    START = 1'b0;
    chk("frame_done_seen", 64'(FRAME_DONE), 64'(1));
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    clr_stats();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_outputs", 64'({PIX_RESET, ERASE, EXPOSE, CONVERT, OUT_VALID, OUT_LAST, FRAME_DONE, BUSY,
                             READBUS, OUT_DATA, OUT_ROW, OUT_COL}), 64'(0));
    chk("reset_bus_released", 64'(DATABUS), 64'(0));
    reset = 1'b0;

    clr_stats();
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy_cycles", 64'(st_busy), 64'(0));

    // Frame A: pattern 10*r+c, consumer always ready.
    seed = 8'd0;
    clr_stats();
    start_pulse();
    wait_done(600, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("erase_cycles", 64'(st_erase), 64'(2));
    chk("expose_cycles", 64'(st_expose), 64'(5));
    chk("convert_cycles", 64'(st_conv), 64'(256));
    chk("gray_first4", 64'({st_first[0], st_first[1], st_first[2], st_first[3]}), 64'(32'h00010302));
    chk("gray_last", 64'(st_lastg), 64'(8'h80));
    chk("readbus_seq", 64'(st_rbseq), 64'(16'h1248));
    chk("frame_len", 64'(st_busy), 64'(289));
    chk("beats", 64'(st_beats), 64'(16));
    chk("last_count", 64'(st_lasts), 64'(1));
    chk("first_beat", 64'(st_first_beat), 64'(0));
    chk("last_beat", 64'(st_last_beat), 64'(33));
    chk("done_pulses", 64'(st_done), 64'(1));

    // Frame B: 30% ready, random pixel offset, stray START pulses mid-frame.
    rand_ready = 1'b1;
    seed = 8'($urandom);
    clr_stats();
    start_pulse();
    wait_done(4000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_beats", 64'(st_beats), 64'(16));
    chk("bp_last_count", 64'(st_lasts), 64'(1));
    chk("bp_first_beat", 64'(st_first_beat), 64'(seed));
    chk("bp_last_beat", 64'(st_last_beat), 64'(8'(seed + 33)));
    chk("bp_done_pulses", 64'(st_done), 64'(1));

    // Reset while converting at cnt=100.
    seed = 8'($urandom);
    clr_stats();
    start_pulse();
    n = 0;
    while (!(cur.convert && cur.gray == gray8(8'd100)) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("conv100_reached", 64'(DATABUS[7:0]), 64'(gray8(8'd100)));
    reset_pulse();
    chk("conv_rst_outputs", 64'({OUT_VALID, BUSY, CONVERT, FRAME_DONE}), 64'(0));
    chk("conv_rst_bus", 64'(DATABUS), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("conv_rst_no_done", 64'(st_done), 64'(0));

    // Reset while streaming row 2, col 1.
    clr_stats();
    start_pulse();
    n = 0;
    while (!(cur.valid && cur.row == 2'd2 && cur.col == 2'd1) && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    chk("r2c1_reached", 64'({OUT_VALID, OUT_ROW, OUT_COL}), 64'({1'b1, 2'd2, 2'd1}));
    reset_pulse();
    chk("strm_rst_outputs", 64'({OUT_VALID, BUSY, FRAME_DONE, READBUS}), 64'(0));
    chk("strm_rst_bus", 64'(DATABUS), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("strm_rst_no_done", 64'(st_done), 64'(0));

    // Frame C: full frame after the interrupted ones.
    seed = 8'($urandom);
    clr_stats();
    start_pulse();
    wait_done(4000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_beats", 64'(st_beats), 64'(16));
    chk("post_last_count", 64'(st_lasts), 64'(1));
    chk("post_last_beat", 64'(st_last_beat), 64'(8'(seed + 33)));
    chk("post_done_pulses", 64'(st_done), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
